memory_stage: RTL and testbench
===============================

# memory_stage

Fourth pipeline stage of the 5-stage MIPS32 core. It holds the EX/MEM pipeline register and the word-organised data memory. Each cycle it captures the execute-stage results, performs one load or store, and presents the load data and ALU result to the writeback register. It also drives the M-stage forwarding value and destination back to the execute stage and the hazard unit.

## Interface
- DEPTH, 256, data memory size in 32-bit words; power of two, at least 4
- AW, 8, word-address width; equals log2(DEPTH)
- clk  input  1  rising-edge clock
- rstN  input  1  reset: one clock; reset is asynchronous and active-low
- regWriteE  input  1  instruction in E writes the register file
- memToRegE  input  1  instruction in E is a load
- memWriteE  input  1  instruction in E is a store
- aluOutE  input  32  ALU result from E, used as the byte address for loads and stores
- writeDataE  input  32  forwarded rt value from E, the store data
- writeRegE  input  5  destination register from E
- regWriteM  output  1  registered regWriteE, qualified by misalignment
- memToRegM  output  1  registered memToRegE
- writeRegM  output  5  registered writeRegE; goes to the hazard unit
- aluOutMOut  output  32  registered aluOutE; forwarding source for E
- readDataM  output  32  load data
- misalignM  output  1  current M instruction is a misaligned load or store
- memErr  output  1  sticky: set by any misaligned access, cleared only by reset

## Operation
- EX/MEM register: on every rising clk it loads regWriteE, memToRegE, memWriteE, aluOutE, writeDataE and writeRegE. There is no stall and no flush input; the hazard unit never holds this register.
- Word address is aluOutM[AW+1:2]. Address bits above AW+1 are ignored, so addresses wrap modulo DEPTH words.
- misalignM = (memToRegM | memWriteM) & (aluOutM[1:0] != 0). It is combinational from the register.
- Store: when memWriteM & ~misalignM, mem[addr] <= writeDataM at the rising clk that ends the M cycle. Only full-word stores exist.
- Load: readDataM = mem[addr] combinationally when memToRegM & ~misalignM; otherwise readDataM = 0.
- Misaligned access:
  - the store is suppressed;
  - readDataM = 0;
  - regWriteM is forced to 0 so a faulty load never writes the register file;
  - memErr is set at the next rising edge.
- Non-memory instructions pass through unchanged: regWriteM = regWriteE delayed one cycle, and aluOutMOut carries the result.
- Memory array contents are not reset. The bench must write before reading.

## Timing
- Reset, asynchronous and immediate on rstN low: all EX/MEM fields are 0, so regWriteM=0, memToRegM=0, writeRegM=0, aluOutMOut=0, readDataM=0, misalignM=0, memErr=0. An in-flight store is dropped. No memory write occurs while rstN is low.
- Latency:
  - E inputs appear on the M outputs one clk after sampling.
  - Load data is valid in the same M cycle, combinationally after the register.
  - Store data becomes visible to a later load one clk after the store's M cycle.
- Store followed immediately by a load to the same address: the load is in M one cycle later and reads the new value.
- While a store is in M, a readDataM probe of the same address returns the old value until the edge. readDataM is 0 anyway, because memToRegM=0.
- memErr goes high one clk after the misaligned M cycle and stays high until rstN is asserted.
- rstN deasserting: capture resumes at the first rising clk after deassertion.

## Test plan
- Reset: drive rstN low mid-run with memWriteE=1 held in the register. Required: all outputs 0 immediately. After release, the target word still holds its old value.
- Store/load: store 0xDEADBEEF to address 0x10, then load 0x10 in the next instruction. Required: readDataM=0xDEADBEEF in the load's M cycle, with regWriteM=1 and memToRegM=1.
- Wrap: with DEPTH=256, store 0x12345678 to address 0x400, then load from 0x000. Required: readDataM=0x12345678.
- Misaligned store to 0x13 with data 0xFFFFFFFF over a word already holding 0xA5A5A5A5. Required: misalignM=1 that cycle, memErr=1 from the next cycle onward, and a load of 0x10 returns 0xA5A5A5A5.
- Misaligned load from 0x22 with regWriteE=1 and writeRegE=5. Required: readDataM=0, regWriteM=0 and writeRegM=5 in that cycle.
- ALU pass-through: aluOutE=0x0000002A, regWriteE=1, writeRegE=9. Required: aluOutMOut=0x2A, writeRegM=9, regWriteM=1 one clk later, and readDataM=0.

Source files
------------

// File: rtl/memory_stage.sv
`default_nettype none
// ============================================================================
// Module  : memory_stage
// Brief   : MIPS32 M stage - EX/MEM pipeline register, word-organised data
//           memory, misalignment detection and sticky error flag.
// Revision: 1.0 - initial release
// ============================================================================
module memory_stage #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        regWriteE,
    input  logic        memToRegE,
    input  logic        memWriteE,
    input  logic [31:0] aluOutE,
    input  logic [31:0] writeDataE,
    input  logic [4:0]  writeRegE,
    output logic        regWriteM,
    output logic        memToRegM,
    output logic [4:0]  writeRegM,
    output logic [31:0] aluOutMOut,
    output logic [31:0] readDataM,
    output logic        misalignM,
    output logic        memErr
);

    logic          r_regWrite;
    logic          r_memToReg;
    logic          r_memWrite;
    logic [31:0]   r_aluOut;
    logic [31:0]   r_writeData;
    logic [4:0]    r_writeReg;
    logic          r_memErr;
    logic [31:0]   r_mem [DEPTH];

    logic [AW-1:0] w_addr;
    logic          w_misalign;
    logic          w_storeEn;

    // EX/MEM register: never stalled or flushed, so it loads every cycle.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_regWrite  <= 1'b0;
            r_memToReg  <= 1'b0;
            r_memWrite  <= 1'b0;
            r_aluOut    <= 32'd0;
            r_writeData <= 32'd0;
            r_writeReg  <= 5'd0;
        end else begin
            r_regWrite  <= regWriteE;
            r_memToReg  <= memToRegE;
            r_memWrite  <= memWriteE;
            r_aluOut    <= aluOutE;
            r_writeData <= writeDataE;
            r_writeReg  <= writeRegE;
        end
    end

    // Upper address bits are dropped, so accesses wrap modulo DEPTH words.
    assign w_addr     = r_aluOut[AW+1:2];
    assign w_misalign = (r_memToReg | r_memWrite) & (r_aluOut[1:0] != 2'b00);
    assign w_storeEn  = r_memWrite & ~w_misalign;

    always_ff @(posedge clk) begin
        if (rstN && w_storeEn) begin
            r_mem[w_addr] <= r_writeData;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_memErr <= 1'b0;
        end else if (w_misalign) begin
            r_memErr <= 1'b1;
        end
    end

    // A faulting load must never reach the register file.
    assign regWriteM  = r_regWrite & ~w_misalign;
    assign memToRegM  = r_memToReg;
    assign writeRegM  = r_writeReg;
    assign aluOutMOut = r_aluOut;
    assign readDataM  = (r_memToReg & ~w_misalign) ? r_mem[w_addr] : 32'd0;
    assign misalignM  = w_misalign;
    assign memErr     = r_memErr;

endmodule
`default_nettype wire

// File: tb/tb_memory_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_memory_stage
// Brief   : Self-checking bench for memory_stage with a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rstN;
    logic        regWriteE, memToRegE, memWriteE;
    logic [31:0] aluOutE, writeDataE;
    logic [4:0]  writeRegE;
    logic        regWriteM, memToRegM, misalignM, memErr;
    logic [4:0]  writeRegM;
    logic [31:0] aluOutMOut, readDataM;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: word array and sticky error flag.
    logic [31:0] mdl_mem [256];
    bit          mdl_err;

    // Expected M-stage outputs for the most recently issued instruction.
    logic        exp_rw, exp_mtr, exp_mis, exp_err;
    logic [4:0]  exp_wr;
    logic [31:0] exp_alu, exp_rd;

    memory_stage #(.DEPTH(256), .AW(8)) dut (
        .clk        (clk),
        .rstN       (rstN),
        .regWriteE  (regWriteE),
        .memToRegE  (memToRegE),
        .memWriteE  (memWriteE),
        .aluOutE    (aluOutE),
        .writeDataE (writeDataE),
        .writeRegE  (writeRegE),
        .regWriteM  (regWriteM),
        .memToRegM  (memToRegM),
        .writeRegM  (writeRegM),
        .aluOutMOut (aluOutMOut),
        .readDataM  (readDataM),
        .misalignM  (misalignM),
        .memErr     (memErr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Drive one instruction into E at a negedge, return at the negedge where
    // it sits in M, with exp_* computed from the architectural rules.
    task automatic issue(input logic rw, input logic mtr, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] wr);
        bit mis;
        int idx;
        regWriteE  = rw;
        memToRegE  = mtr;
        memWriteE  = mw;
        aluOutE    = alu;
        writeDataE = wd;
        writeRegE  = wr;
        @(posedge clk);
        @(negedge clk);
        mis     = (mtr || mw) && (alu % 4 != 0);
        idx     = int'((alu / 4) % 256);
        exp_mis = mis;
        exp_rw  = rw && !mis;
        exp_mtr = mtr;
        exp_wr  = wr;
        exp_alu = alu;
        exp_rd  = (mtr && !mis) ? mdl_mem[idx] : 32'd0;
        exp_err = mdl_err;
        if (mw && !mis) mdl_mem[idx] = wd;
        if (mis) mdl_err = 1'b1;
    endtask

    task automatic test_reset;
        rstN = 1'b0;
        regWriteE = 0; memToRegE = 0; memWriteE = 0;
        aluOutE = 0; writeDataE = 0; writeRegE = 0;
        mdl_err = 1'b0;
        #1;
        total++;
        if ({regWriteM, memToRegM, writeRegM, aluOutMOut, readDataM, misalignM, memErr} !== '0) begin
            bad++;
            $display("FAIL reset_init outputs got rw=%b mtr=%b wr=%0d alu=%h rd=%h mis=%b err=%b exp all 0",
                     regWriteM, memToRegM, writeRegM, aluOutMOut, readDataM, misalignM, memErr);
        end
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic preload;
        for (int i = 0; i < 256; i++) begin
            issue(1'b0, 1'b0, 1'b1, 32'(i * 4), $urandom, 5'd0);
        end
    endtask

    task automatic test_store_load;
        issue(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0);
        issue(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd3);
        total++;
        if (readDataM !== 32'hDEADBEEF) begin
            bad++; $display("FAIL store_load readDataM got=%h exp=deadbeef", readDataM);
        end
        total++;
        if (regWriteM !== 1'b1) begin
            bad++; $display("FAIL store_load regWriteM got=%b exp=1", regWriteM);
        end
        total++;
        if (memToRegM !== 1'b1) begin
            bad++; $display("FAIL store_load memToRegM got=%b exp=1", memToRegM);
        end
    endtask

    task automatic test_wrap;
        issue(1'b0, 1'b0, 1'b1, 32'h400, 32'h12345678, 5'd0);
        issue(1'b1, 1'b1, 1'b0, 32'h000, 32'h0, 5'd4);
        total++;
        if (readDataM !== 32'h12345678) begin
            bad++; $display("FAIL wrap readDataM got=%h exp=12345678", readDataM);
        end
    endtask

    task automatic test_misaligned_store;
        issue(1'b0, 1'b0, 1'b1, 32'h10, 32'hA5A5A5A5, 5'd0);
        issue(1'b0, 1'b0, 1'b1, 32'h13, 32'hFFFFFFFF, 5'd0);
        total++;
        if (misalignM !== 1'b1) begin
            bad++; $display("FAIL mis_store misalignM got=%b exp=1", misalignM);
        end
        total++;
        if (memErr !== 1'b0) begin
            bad++; $display("FAIL mis_store memErr_same_cycle got=%b exp=0", memErr);
        end
        issue(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd7);
        total++;
        if (memErr !== 1'b1) begin
            bad++; $display("FAIL mis_store memErr_next got=%b exp=1", memErr);
        end
        total++;
        if (readDataM !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL mis_store readback got=%h exp=a5a5a5a5", readDataM);
        end
    endtask

    task automatic test_misaligned_load;
        issue(1'b1, 1'b1, 1'b0, 32'h22, 32'h0, 5'd5);
        total++;
        if (readDataM !== 32'd0) begin
            bad++; $display("FAIL mis_load readDataM got=%h exp=0", readDataM);
        end
        total++;
        if (regWriteM !== 1'b0) begin
            bad++; $display("FAIL mis_load regWriteM got=%b exp=0", regWriteM);
        end
        total++;
        if (writeRegM !== 5'd5) begin
            bad++; $display("FAIL mis_load writeRegM got=%0d exp=5", writeRegM);
        end
        total++;
        if (misalignM !== 1'b1) begin
            bad++; $display("FAIL mis_load misalignM got=%b exp=1", misalignM);
        end
    endtask

    task automatic test_passthrough;
        issue(1'b1, 1'b0, 1'b0, 32'h2A, 32'h0, 5'd9);
        total++;
        if (aluOutMOut !== 32'h2A) begin
            bad++; $display("FAIL pass aluOutMOut got=%h exp=2a", aluOutMOut);
        end
        total++;
        if (writeRegM !== 5'd9) begin
            bad++; $display("FAIL pass writeRegM got=%0d exp=9", writeRegM);
        end
        total++;
        if (regWriteM !== 1'b1) begin
            bad++; $display("FAIL pass regWriteM got=%b exp=1", regWriteM);
        end
        total++;
        if (readDataM !== 32'd0 || misalignM !== 1'b0) begin
            bad++; $display("FAIL pass rd/mis got=%h/%b exp=0/0", readDataM, misalignM);
        end
    endtask

    // Reset lands while a store to 0x10 sits in M; the store must be dropped.
    task automatic test_reset_midrun;
        regWriteE = 0; memToRegE = 0; memWriteE = 1;
        aluOutE = 32'h10; writeDataE = 32'h11223344; writeRegE = 5'd2;
        @(posedge clk);
        #1 rstN = 1'b0;
        #1;
        total++;
        if ({regWriteM, memToRegM, writeRegM, aluOutMOut, readDataM, misalignM, memErr} !== '0) begin
            bad++;
            $display("FAIL reset_mid outputs got rw=%b mtr=%b wr=%0d alu=%h rd=%h mis=%b err=%b exp all 0",
                     regWriteM, memToRegM, writeRegM, aluOutMOut, readDataM, misalignM, memErr);
        end
        memWriteE = 0; aluOutE = 0; writeDataE = 0; writeRegE = 0;
        mdl_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstN = 1'b1;
        issue(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd1);
        total++;
        if (readDataM !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL reset_mid old_word got=%h exp=a5a5a5a5", readDataM);
        end
        total++;
        if (memErr !== 1'b0) begin
            bad++; $display("FAIL reset_mid memErr got=%b exp=0", memErr);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 300; n++) begin
            int kind;
            logic [31:0] a;
            kind = int'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 1) != 0) a[31:12] = '0;
            issue(1'($urandom), kind == 1, kind == 2, a, $urandom, 5'($urandom));
            total++;
            if ({regWriteM, memToRegM, writeRegM, aluOutMOut, readDataM, misalignM, memErr} !==
                {exp_rw, exp_mtr, exp_wr, exp_alu, exp_rd, exp_mis, exp_err}) begin
                bad++;
                $display("FAIL random[%0d] got rw=%b mtr=%b wr=%0d alu=%h rd=%h mis=%b err=%b exp rw=%b mtr=%b wr=%0d alu=%h rd=%h mis=%b err=%b",
                         n, regWriteM, memToRegM, writeRegM, aluOutMOut, readDataM, misalignM, memErr,
                         exp_rw, exp_mtr, exp_wr, exp_alu, exp_rd, exp_mis, exp_err);
            end
        end
    endtask

    initial begin
        test_reset();
        preload();
        test_store_load();
        test_wrap();
        test_misaligned_store();
        test_misaligned_load();
        test_passthrough();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
